// File: rtl/emif_amm_req_gen.sv
// emif_amm_req_gen: turns the tagged single-line request stream into registered
// Avalon-MM commands (one beat each). Read tags are queued in a FIFO and returned
// with the read data. Reads are never accepted beyond MAX_RD outstanding.
// Optional build macro EMIF_AMM_PERF_CNT_EN adds saturating perf counters.
module emif_amm_req_gen #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 576,
  parameter int BE_W   = 72,
  parameter int TAG_W  = 8,
  parameter int MAX_RD = 64
) (
  input  logic                      emif_usr_clk,
  input  logic                      emif_usr_reset,
  input  logic                      local_cal_success,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [BE_W-1:0]           req_be,
  input  logic [TAG_W-1:0]          req_tag,
  output logic                      rsp_valid,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic [DATA_W-1:0]         rsp_rdata,
  input  logic                      amm_ready,
  output logic                      amm_read,
  output logic                      amm_write,
  output logic [ADDR_W-1:0]         amm_address,
  output logic [DATA_W-1:0]         amm_writedata,
  output logic [BE_W-1:0]           amm_byteenable,
  output logic [6:0]                amm_burstcount,
  input  logic                      amm_readdatavalid,
  input  logic [DATA_W-1:0]         amm_readdata,
  output logic [$clog2(MAX_RD):0]   rd_outstanding,
  output logic                      err_underflow
`ifdef EMIF_AMM_PERF_CNT_EN
  ,
  output logic [31:0]               perf_rd_cnt,
  output logic [31:0]               perf_wr_cnt,
  output logic [31:0]               perf_stall_cnt
`endif
);

  localparam int AW = $clog2(MAX_RD);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_RD);

  logic             cal_ok;
  logic             cmd_vld;
  logic             cmd_done;
  logic             credit_ok;
  logic             accept;
  logic             rd_push;
  logic             rd_pop;
  logic             fifo_empty;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [TAG_W-1:0] tag_mem [MAX_RD];

  assign cmd_vld        = amm_read | amm_write;
  assign cmd_done       = cmd_vld & amm_ready;
  assign credit_ok      = rd_outstanding < MAX_CNT;
  // Ready may overlap the completing command so commands stream back to back.
  assign req_ready      = cal_ok && (!cmd_vld || amm_ready) && (req_write || credit_ok);
  assign accept         = req_valid && req_ready;
  assign rd_push        = accept && !req_write;
  assign fifo_empty     = (rd_outstanding == '0);
  assign rd_pop         = amm_readdatavalid && !fifo_empty;
  assign amm_burstcount = 7'd1;

  // Calibration status retimed into the user clock domain.
  always_ff @(posedge emif_usr_clk) begin
    if (emif_usr_reset) cal_ok <= 1'b0;
    else                cal_ok <= local_cal_success;
  end

  // Command register: load on accept, clear on completion, otherwise hold.
  always_ff @(posedge emif_usr_clk) begin
    if (emif_usr_reset) begin
      amm_read       <= 1'b0;
      amm_write      <= 1'b0;
      amm_address    <= '0;
      amm_writedata  <= '0;
      amm_byteenable <= '0;
    end else if (accept) begin
      amm_read       <= !req_write;
      amm_write      <= req_write;
      amm_address    <= req_addr;
      amm_writedata  <= req_wdata;
      amm_byteenable <= req_write ? req_be : '1;
    end else if (cmd_done) begin
      amm_read  <= 1'b0;
      amm_write <= 1'b0;
    end
  end

  // Tag storage; contents need no reset since the pointers define validity.
  always_ff @(posedge emif_usr_clk) begin
    if (rd_push) tag_mem[wr_ptr] <= req_tag;
  end

  // FIFO pointers and outstanding-read count (count doubles as FIFO occupancy).
  always_ff @(posedge emif_usr_clk) begin
    if (emif_usr_reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rd_outstanding <= '0;
    end else begin
      if (rd_push) wr_ptr <= wr_ptr + 1'b1;
      if (rd_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({rd_push, rd_pop})
        2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
        2'b01:   rd_outstanding <= rd_outstanding - 1'b1;
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

  // Read response: tag from FIFO head plus registered EMIF data.
  always_ff @(posedge emif_usr_clk) begin
    if (emif_usr_reset) begin
      rsp_valid <= 1'b0;
      rsp_tag   <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rd_pop;
      if (rd_pop) begin
        rsp_tag   <= tag_mem[rd_ptr];
        rsp_rdata <= amm_readdata;
      end
    end
  end

  // Sticky flag for read data arriving with no tag to pair it with.
  always_ff @(posedge emif_usr_clk) begin
    if (emif_usr_reset)                        err_underflow <= 1'b0;
    else if (amm_readdatavalid && fifo_empty)  err_underflow <= 1'b1;
  end

`ifdef EMIF_AMM_PERF_CNT_EN
  // Saturating performance counters for completed commands and stall cycles.
  always_ff @(posedge emif_usr_clk) begin
    if (emif_usr_reset) begin
      perf_rd_cnt    <= '0;
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (cmd_done && amm_read && (perf_rd_cnt != '1))   perf_rd_cnt    <= perf_rd_cnt + 1'b1;
      if (cmd_done && amm_write && (perf_wr_cnt != '1))  perf_wr_cnt    <= perf_wr_cnt + 1'b1;
      if (cmd_vld && !amm_ready && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_emif_amm_req_gen.sv
// Self-checking bench for emif_amm_req_gen: directed phases plus a randomized
// phase, all checked against a queue-based transaction model.
module tb_emif_amm_req_gen;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 576;
  localparam int BE_W   = 72;
  localparam int TAG_W  = 8;
  localparam int MAX_RD = 64;

  typedef logic [DATA_W-1:0] wide_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cal;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_W-1:0]       req_addr;
  logic [DATA_W-1:0]       req_wdata;
  logic [BE_W-1:0]         req_be;
  logic [TAG_W-1:0]        req_tag;
  logic                    rsp_valid;
  logic [TAG_W-1:0]        rsp_tag;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    amm_ready;
  logic                    amm_read;
  logic                    amm_write;
  logic [ADDR_W-1:0]       amm_address;
  logic [DATA_W-1:0]       amm_writedata;
  logic [BE_W-1:0]         amm_byteenable;
  logic [6:0]              amm_burstcount;
  logic                    amm_readdatavalid;
  logic [DATA_W-1:0]       amm_readdata;
  logic [$clog2(MAX_RD):0] rd_outstanding;
  logic                    err_underflow;
`ifdef EMIF_AMM_PERF_CNT_EN
  logic [31:0]             perf_rd_cnt;
  logic [31:0]             perf_wr_cnt;
  logic [31:0]             perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  emif_amm_req_gen #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .BE_W  (BE_W),
    .TAG_W (TAG_W),
    .MAX_RD(MAX_RD)
  ) dut (
    .emif_usr_clk     (clk),
    .emif_usr_reset   (rst),
    .local_cal_success(cal),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_be           (req_be),
    .req_tag          (req_tag),
    .rsp_valid        (rsp_valid),
    .rsp_tag          (rsp_tag),
    .rsp_rdata        (rsp_rdata),
    .amm_ready        (amm_ready),
    .amm_read         (amm_read),
    .amm_write        (amm_write),
    .amm_address      (amm_address),
    .amm_writedata    (amm_writedata),
    .amm_byteenable   (amm_byteenable),
    .amm_burstcount   (amm_burstcount),
    .amm_readdatavalid(amm_readdatavalid),
    .amm_readdata     (amm_readdata),
`ifdef EMIF_AMM_PERF_CNT_EN
    .perf_rd_cnt      (perf_rd_cnt),
    .perf_wr_cnt      (perf_wr_cnt),
    .perf_stall_cnt   (perf_stall_cnt),
`endif
    .rd_outstanding   (rd_outstanding),
    .err_underflow    (err_underflow)
  );

  // Transaction model: calibration flag, the one pending command, the queue of
  // tags awaiting data, the last response and the sticky error.
  bit                m_cal;
  bit                m_rd;
  bit                m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [BE_W-1:0]   m_be;
  bit                m_rsp_v;
  logic [TAG_W-1:0]  m_rsp_tag;
  logic [DATA_W-1:0] m_rsp_data;
  bit                m_err;
  logic [TAG_W-1:0]  m_q[$];
  int unsigned       m_prd, m_pwr, m_pstall;
  int unsigned       n_reads;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input wide_t obs, input wide_t exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wide_t rand_wide();
    wide_t v = '0;
    for (int i = 0; i < DATA_W / 32; i++) v = {v[DATA_W-33:0], $urandom()};
    return v;
  endfunction

  function automatic void model_reset();
    m_cal = 0; m_rd = 0; m_wr = 0;
    m_addr = '0; m_wdata = '0; m_be = '0;
    m_rsp_v = 0; m_rsp_tag = '0; m_rsp_data = '0;
    m_err = 0; m_q.delete();
    m_prd = 0; m_pwr = 0; m_pstall = 0;
  endfunction

  // One clock: check ready against the model, advance the model over the edge,
  // then check every registered output.
  task automatic tick();
    bit e_ready;
    #1;
    e_ready = m_cal && (!(m_rd || m_wr) || amm_ready) &&
              (req_write || (m_q.size() < MAX_RD));
    chk("req_ready", wide_t'(req_ready), wide_t'(e_ready));
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_cal = cal;
      if (amm_readdatavalid) begin
        if (m_q.size() != 0) begin
          m_rsp_v    = 1;
          m_rsp_tag  = m_q.pop_front();
          m_rsp_data = amm_readdata;
        end else begin
          m_rsp_v = 0;
          m_err   = 1;
        end
      end else begin
        m_rsp_v = 0;
      end
      if (m_rd || m_wr) begin
        if (amm_ready) begin
          if (m_rd) m_prd++;
          else      m_pwr++;
        end else begin
          m_pstall++;
        end
      end
      if (req_valid && e_ready) begin
        m_rd    = !req_write;
        m_wr    = req_write;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_be    = req_write ? req_be : '1;
        if (!req_write) begin
          m_q.push_back(req_tag);
          n_reads++;
        end
      end else if ((m_rd || m_wr) && amm_ready) begin
        m_rd = 0;
        m_wr = 0;
      end
    end
    chk("amm_read", wide_t'(amm_read), wide_t'(m_rd));
    chk("amm_write", wide_t'(amm_write), wide_t'(m_wr));
    chk("burstcount", wide_t'(amm_burstcount), wide_t'(7'd1));
    if (m_rd || m_wr) begin
      chk("amm_address", wide_t'(amm_address), wide_t'(m_addr));
      chk("amm_byteenable", wide_t'(amm_byteenable), wide_t'(m_be));
    end
    if (m_wr) chk("amm_writedata", amm_writedata, m_wdata);
    chk("rsp_valid", wide_t'(rsp_valid), wide_t'(m_rsp_v));
    if (m_rsp_v) begin
      chk("rsp_tag", wide_t'(rsp_tag), wide_t'(m_rsp_tag));
      chk("rsp_rdata", rsp_rdata, m_rsp_data);
    end
    chk("rd_outstanding", wide_t'(rd_outstanding), wide_t'(m_q.size()));
    chk("err_underflow", wide_t'(err_underflow), wide_t'(m_err));
`ifdef EMIF_AMM_PERF_CNT_EN
    chk("perf_rd_cnt", wide_t'(perf_rd_cnt), wide_t'(m_prd));
    chk("perf_wr_cnt", wide_t'(perf_wr_cnt), wide_t'(m_pwr));
    chk("perf_stall_cnt", wide_t'(perf_stall_cnt), wide_t'(m_pstall));
`endif
  endtask

  initial begin
    rst = 1; cal = 0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    req_be = '0; req_tag = '0;
    amm_ready = 0; amm_readdatavalid = 0; amm_readdata = '0;
    n_reads = 0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset values
    tick();
    tick();
    chk("rst_address", wide_t'(amm_address), '0);
    chk("rst_writedata", amm_writedata, '0);
    chk("rst_byteenable", wide_t'(amm_byteenable), '0);
    chk("rst_rsp_tag", wide_t'(rsp_tag), '0);
    chk("rst_rsp_rdata", rsp_rdata, '0);

    // No accepts before calibration, then a write stalled for five cycles
    rst = 0;
    req_valid = 1; req_write = 1;
    req_addr = 27'h123; req_be = 72'hFF; req_wdata = rand_wide();
    repeat (6) tick();
    chk("ready_nocal", wide_t'(req_ready), '0);
    cal = 1;
    tick();
    tick();
    req_valid = 0;
    repeat (5) tick();
    chk("wr_held_addr", wide_t'(amm_address), wide_t'(27'h123));
    chk("wr_held_write", wide_t'(amm_write), wide_t'(1'b1));
    amm_ready = 1;
    tick();
    chk("wr_done", wide_t'(amm_write), '0);

    // Fill every read credit, then one return frees exactly one
    req_valid = 1; req_write = 0;
    for (int i = 0; i < MAX_RD; i++) begin
      req_tag  = TAG_W'(i);
      req_addr = ADDR_W'($urandom());
      tick();
    end
    req_tag = TAG_W'(MAX_RD);
    tick();
    tick();
    chk("credit_full_cnt", wide_t'(rd_outstanding), wide_t'(MAX_RD));
    amm_readdatavalid = 1; amm_readdata = rand_wide();
    tick();
    chk("first_rsp_tag", wide_t'(rsp_tag), '0);
    amm_readdatavalid = 0;
    tick();
    chk("blocked_rd_issued", wide_t'(amm_read), wide_t'(1'b1));
    req_valid = 0;

    // Drain to 10 outstanding, then push and pop together
    amm_readdatavalid = 1;
    for (int i = 0; i < 2 * MAX_RD && m_q.size() > 10; i++) begin
      amm_readdata = rand_wide();
      tick();
    end
    req_valid = 1; req_write = 0; req_tag = 8'hA5; amm_readdata = rand_wide();
    tick();
    chk("push_pop_cnt", wide_t'(rd_outstanding), wide_t'(10));

    // Randomized traffic; many reads so the tag FIFO pointers wrap repeatedly
    for (int i = 0; i < 800; i++) begin
      req_valid         = ($urandom_range(0, 3) != 0);
      req_write         = ($urandom_range(0, 4) == 0);
      req_addr          = ADDR_W'($urandom());
      req_tag           = TAG_W'($urandom());
      req_be            = BE_W'({$urandom(), $urandom(), $urandom()});
      req_wdata         = rand_wide();
      amm_ready         = ($urandom_range(0, 3) != 0);
      amm_readdatavalid = (m_q.size() != 0) && ($urandom_range(0, 1) == 1);
      amm_readdata      = rand_wide();
      tick();
    end
    chk("many_reads", wide_t'(n_reads >= 200), wide_t'(1'b1));
    req_valid = 0; amm_ready = 1;
    for (int i = 0; i < 2 * MAX_RD && m_q.size() != 0; i++) begin
      amm_readdatavalid = 1;
      amm_readdata      = rand_wide();
      tick();
    end
    amm_readdatavalid = 0;
    tick();
    chk("drained", wide_t'(rd_outstanding), '0);

    // Calibration lost while a command is stalled
    req_valid = 1; req_write = 1; req_addr = 27'h55; req_wdata = rand_wide();
    amm_ready = 0;
    tick();
    cal = 0;
    repeat (3) tick();
    amm_ready = 1;
    tick();
    tick();
    chk("ready_cal_lost", wide_t'(req_ready), '0);
    cal = 1; req_valid = 0;
    tick();
    tick();

    // Return with nothing outstanding
    amm_readdatavalid = 1; amm_readdata = rand_wide();
    tick();
    amm_readdatavalid = 0;
    repeat (3) tick();
    chk("underflow_sticky", wide_t'(err_underflow), wide_t'(1'b1));

    // Reset with a pending read, then a late return
    req_valid = 1; req_write = 0; req_tag = 8'h3C; amm_ready = 0;
    tick();
    rst = 1; req_valid = 0;
    tick();
    chk("rst_abandon_rd", wide_t'(amm_read), '0);
    chk("rst_clears_err", wide_t'(err_underflow), '0);
    rst = 0;
    amm_readdatavalid = 1;
    tick();
    amm_readdatavalid = 0;
    tick();
    chk("late_return_err", wide_t'(err_underflow), wide_t'(1'b1));

    // Perf mix after a fresh reset: 3 reads, 2 writes, 4 stall cycles
    rst = 1; amm_ready = 1;
    tick();
    rst = 0;
    tick();
    tick();
    req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      req_write = (i >= 3);
      req_tag   = TAG_W'(i);
      amm_ready = 1;
      tick();
      if (i == 1) begin
        req_valid = 0; amm_ready = 0;
        repeat (4) tick();
        req_valid = 1;
      end
    end
    req_valid = 0; amm_ready = 1;
    tick();
    tick();
`ifdef EMIF_AMM_PERF_CNT_EN
    chk("perf_rd_3", wide_t'(perf_rd_cnt), wide_t'(3));
    chk("perf_wr_2", wide_t'(perf_wr_cnt), wide_t'(2));
    chk("perf_stall_4", wide_t'(perf_stall_cnt), wide_t'(4));
`endif
    chk("perf_mix_cnt", wide_t'(rd_outstanding), wide_t'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/emif_amm_req_gen.md
# emif_amm_req_gen

Request generator sitting directly upstream of the EMIF controller's Avalon-MM port 0. It converts the tagged single-line request stream from the memory-side traffic logic into registered Avalon-MM commands, one 576-bit beat per command. It tracks outstanding reads in a tag FIFO and returns read data with its original tag, one cycle after EMIF read data arrives. It never accepts more reads than it can tag.

## Interface
Parameters:
- ADDR_W, 27, Avalon word address width
- DATA_W, 576, data width (512 data + 64 ECC/meta)
- BE_W, 72, byte-enable width (DATA_W/8)
- TAG_W, 8, request tag width
- MAX_RD, 64, max outstanding reads; power of 2, 2..256

Ports (clock and reset first):
- emif_usr_clk  in  1  EMIF user clock; the only clock. Every register is clocked on the rising edge.
- emif_usr_reset  in  1  synchronous, active-high reset
- local_cal_success  in  1  EMIF calibration done
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  BE_W  write byte enables
- req_tag  in  TAG_W  tag returned with read data
- rsp_valid  out  1  read data valid; no backpressure
- rsp_tag  out  TAG_W  tag of returned read
- rsp_rdata  out  DATA_W  read data
- amm_ready  in  1  EMIF waitrequest_n
- amm_read  out  1  read command
- amm_write  out  1  write command
- amm_address  out  ADDR_W  command address
- amm_writedata  out  DATA_W  write data
- amm_byteenable  out  BE_W  byte enables; all-ones for reads
- amm_burstcount  out  7  constant 7'd1
- amm_readdatavalid  in  1  EMIF read data valid
- amm_readdata  in  DATA_W  EMIF read data
- rd_outstanding  out  $clog2(MAX_RD)+1  reads issued but not yet returned, including a pending command
- err_underflow  out  1  sticky: readdatavalid arrived while the tag FIFO was empty

## Operation
- Reset values:
  - req_ready=0, amm_read=0, amm_write=0, rsp_valid=0, rd_outstanding=0, err_underflow=0.
  - amm_address, amm_writedata, amm_byteenable, rsp_tag and rsp_rdata reset to 0.
  - Tag FIFO is emptied.
- cal_ok is local_cal_success registered once.
- Command register:
  - Holds a single command, cmd_vld.
  - Command completes on the cycle where (amm_read||amm_write)&&amm_ready.
  - All amm_* outputs are held stable while amm_ready=0.
- req_ready = cal_ok && (!cmd_vld || amm_ready) && (req_write || credit_ok), where credit_ok = rd_outstanding < MAX_RD.
  - req_ready for writes does not depend on credits.
- Accept (req_valid&&req_ready): load the command register next cycle.
  - amm_read=!req_write, amm_write=req_write.
  - Reads: byteenable all-ones.
- Read accept: push req_tag to the tag FIFO (depth MAX_RD) and increment rd_outstanding.
- amm_readdatavalid: pop the FIFO head into rsp_tag, register amm_readdata into rsp_rdata, set rsp_valid for 1 cycle, and decrement rd_outstanding.
- Simultaneous push and pop: count is unchanged; FIFO read and write pointers both advance.
- FIFO full cannot occur; credit_ok prevents it.
- readdatavalid with an empty FIFO:
  - Data is dropped and rsp_valid stays 0.
  - err_underflow is set and held until reset.
- cal_ok falling: no new accepts; an already-loaded command still completes, and returns are still delivered.
- Reset mid-operation:
  - Pending command is abandoned (amm_read/amm_write go to 0 next cycle).
  - FIFO and count are cleared.
  - Late EMIF returns set err_underflow.

## Timing
- Request accepted in cycle N → amm_read/amm_write high in cycle N+1.
- Throughput is 1 command per cycle while amm_ready=1 (back-to-back accept during completion).
- amm_readdatavalid in cycle M → rsp_valid in cycle M+1. rsp_valid is never stalled.
- Reset asserted in cycle R → all outputs at reset values in cycle R+1.
- After local_cal_success rises, req_ready can first be 1 two cycles later.
- Credit is consumed at accept and returned in the cycle after readdatavalid. A read is therefore accepted in the cycle after the limit clears.

## Configuration
- EMIF_AMM_PERF_CNT_EN defined: add outputs perf_rd_cnt, perf_wr_cnt and perf_stall_cnt (32 bits each, reset 0).
  - perf_rd_cnt counts completed read commands.
  - perf_wr_cnt counts completed write commands.
  - perf_stall_cnt counts cycles with a command pending and amm_ready=0.
  - All three saturate at 32'hFFFF_FFFF.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

## Test plan
- Reset, local_cal_success=0, req_valid=1 → req_ready=0 indefinitely. Raise cal → req_ready=1 two cycles later.
- Write addr 27'h123, be 72'hFF, amm_ready=0 for 5 cycles → amm_write/address/data held constant 5 cycles, complete on 6th; burstcount=1 throughout.
- 64 reads, tags 0..63, with readdatavalid held 0 → 65th read blocked, rd_outstanding=64. One return → rsp_tag=0 the next cycle, and the blocked read is accepted one cycle later.
- Push and pop in the same cycle at rd_outstanding=10 → count stays 10; rsp_tag order matches issue order across FIFO pointer wrap (200 reads).
- readdatavalid with an empty FIFO → rsp_valid stays 0, err_underflow=1 until emif_usr_reset.
- With EMIF_AMM_PERF_CNT_EN: 3 reads, 2 writes, 4 stall cycles → counters read 3, 2, 4.
